// File: rtl/bidir_bus_pkg.sv
// ----------------------------------------------------------------------------
// bidir_bus_pkg : shared state encoding and bus width for bidir_bus_ctrl
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bidir_bus_pkg;

   localparam int BUS_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TX   = 2'd1,
      TURN = 2'd2,
      RX   = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/bidir_tx_fifo.sv
// ----------------------------------------------------------------------------
// bidir_tx_fifo : power-of-two byte FIFO with show-ahead head output
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bidir_tx_fifo
   import bidir_bus_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [BUS_W-1:0] push_data,
   input  logic             pop,
   output logic [BUS_W-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [BUS_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

`default_nettype wire

// File: rtl/bidir_bus_ctrl.sv
// ----------------------------------------------------------------------------
// bidir_bus_ctrl : half-duplex bus controller, TX FIFO plus IDLE/TX/TURN/RX FSM
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bidir_bus_ctrl
   import bidir_bus_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int TURN_CYC = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_valid,
   input  logic [BUS_W-1:0] tx_data,
   output logic             tx_ready,
   input  logic             rx_req,
   output logic             rx_valid,
   output logic [BUS_W-1:0] rx_data,
   output logic             send,
   output logic [BUS_W-1:0] send_data,
   output logic             rcv,
   input  logic [BUS_W-1:0] received_data,
   output logic             busy
);

   localparam int         CW        = $clog2(DEPTH) + 1;
   localparam logic [2:0] TURN_LAST = 3'(TURN_CYC - 1);

   state_t           state;
   logic             rx_pend;
   logic [2:0]       turn_cnt;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [BUS_W-1:0] fifo_head;
   logic             push;
   logic             pop;

   assign tx_ready = ~fifo_full;
   assign push     = tx_valid & tx_ready;
   assign pop      = ((state == IDLE) || (state == TX)) && !fifo_empty;
   assign busy     = (state != IDLE) || (fifo_count != '0) || rx_pend;

   bidir_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (tx_data),
      .pop       (pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rx_pend   <= 1'b0;
         turn_cnt  <= 3'd0;
         send      <= 1'b0;
         send_data <= '0;
         rcv       <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (rx_req) rx_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state     <= TX;
                  send      <= 1'b1;
                  send_data <= fifo_head;
               end else if (rx_pend) begin
                  // A request landing on the entry edge stays pending for the next round.
                  state   <= RX;
                  rcv     <= 1'b1;
                  rx_pend <= rx_req;
               end
            end
            TX: begin
               if (!fifo_empty) begin
                  send_data <= fifo_head;
               end else begin
                  state     <= TURN;
                  send      <= 1'b0;
                  send_data <= '0;
                  turn_cnt  <= 3'd0;
               end
            end
            TURN: begin
               if (turn_cnt == TURN_LAST) begin
                  state    <= IDLE;
                  turn_cnt <= 3'd0;
               end else begin
                  turn_cnt <= turn_cnt + 3'd1;
               end
            end
            RX: begin
               state    <= TURN;
               rcv      <= 1'b0;
               rx_data  <= received_data;
               rx_valid <= 1'b1;
               turn_cnt <= 3'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bidir_bus_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bidir_bus_ctrl : directed self-checking bench for bidir_bus_ctrl
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bidir_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       rx_req;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       send;
   logic [7:0] send_data;
   logic       rcv;
   logic [7:0] received_data;
   logic       busy;

   int total = 0;
   int bad   = 0;

   bidir_bus_ctrl #(
      .DEPTH    (4),
      .TURN_CYC (5)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .rx_req        (rx_req),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .send          (send),
      .send_data     (send_data),
      .rcv           (rcv),
      .received_data (received_data),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One-byte burst, then four pushes during the 5-cycle TURN; returns in the
   // first cycle of the second burst (send_data should be AB, 3 bytes left).
   task automatic burst_to_tx();
      tx_valid = 1'b1; tx_data = 8'h01;
      step();
      tx_valid = 1'b0;
      step();
      chk8("prior_send_data", send_data, 8'h01);
      step();
      chkb("turn_ready", tx_ready, 1'b1);
      tx_valid = 1'b1; tx_data = 8'hAB; step();
      tx_data = 8'h34; step();
      tx_data = 8'h11; step();
      tx_data = 8'h21; step();
      chkb("full_ready", tx_ready, 1'b0);
      tx_data = 8'h77; step();
      chkb("full_pop_ready", tx_ready, 1'b0);
      tx_data = 8'h99; step();
      tx_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_seq [4];
      int         n_send;
      int         n_rcv;
      int         n_val;
      int         overlap;

      exp_seq[0] = 8'hAB; exp_seq[1] = 8'h34; exp_seq[2] = 8'h11; exp_seq[3] = 8'h21;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_req = 1'b0; received_data = 8'h00;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chkb("rst_send", send, 1'b0);
      chkb("rst_rcv", rcv, 1'b0);
      chkb("rst_rx_valid", rx_valid, 1'b0);
      chk8("rst_send_data", send_data, 8'h00);
      chk8("rst_rx_data", rx_data, 8'h00);
      chkb("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      step();
      chkb("rst_tx_ready", tx_ready, 1'b1);

      // Single TX
      tx_valid = 1'b1; tx_data = 8'h15;
      step();
      tx_valid = 1'b0;
      chkb("single_c1_send", send, 1'b0);
      chkb("single_c1_busy", busy, 1'b1);
      step();
      chkb("single_c2_send", send, 1'b1);
      chk8("single_c2_data", send_data, 8'h15);
      step();
      chkb("single_c3_send", send, 1'b0);
      chk8("single_c3_data", send_data, 8'h00);
      repeat (4) step();
      chkb("single_c7_busy", busy, 1'b1);
      step();
      chkb("single_c8_busy", busy, 1'b0);

      // Burst into a full FIFO
      burst_to_tx();
      for (int i = 0; i < 4; i++) begin
         chkb("burst_send", send, 1'b1);
         chk8("burst_data", send_data, exp_seq[i]);
         step();
      end
      chkb("burst_end_send", send, 1'b0);
      repeat (5) step();
      chkb("burst_idle_busy", busy, 1'b0);

      // RX
      received_data = 8'h66;
      rx_req = 1'b1;
      step();
      rx_req = 1'b0;
      chkb("rx_c1_rcv", rcv, 1'b0);
      step();
      chkb("rx_c2_rcv", rcv, 1'b1);
      chkb("rx_c2_valid", rx_valid, 1'b0);
      step();
      received_data = 8'h00;
      chkb("rx_c3_rcv", rcv, 1'b0);
      chkb("rx_c3_valid", rx_valid, 1'b1);
      chk8("rx_c3_data", rx_data, 8'h66);
      step();
      chkb("rx_c4_valid", rx_valid, 1'b0);
      chk8("rx_c4_hold", rx_data, 8'h66);
      repeat (4) step();
      chkb("rx_idle_busy", busy, 1'b0);

      // Contention: TX first, then RX after the turnaround
      received_data = 8'h5A;
      rx_req = 1'b1; tx_valid = 1'b1; tx_data = 8'h12;
      step();
      rx_req = 1'b0; tx_valid = 1'b0;
      overlap = 0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         chkb("cont_send", send, cyc == 2);
         chkb("cont_rcv", rcv, cyc == 9);
         if (cyc == 2) chk8("cont_data", send_data, 8'h12);
         if (cyc == 10) begin
            chkb("cont_valid", rx_valid, 1'b1);
            chk8("cont_rx_data", rx_data, 8'h5A);
         end
         if (send && rcv) overlap++;
         step();
      end
      chki("cont_overlap", overlap, 0);
      repeat (4) step();
      chkb("cont_idle_busy", busy, 1'b0);

      // Merge three rx_req pulses during a TX burst
      n_send = 0; n_rcv = 0; n_val = 0; overlap = 0;
      for (int cyc = 0; cyc <= 20; cyc++) begin
         if (send)     n_send++;
         if (rcv)      n_rcv++;
         if (rx_valid) n_val++;
         if (send && rcv) overlap++;
         tx_valid = (cyc <= 2);
         tx_data  = 8'hA1 + 8'(cyc);
         rx_req   = (cyc >= 2) && (cyc <= 4);
         step();
      end
      tx_valid = 1'b0; rx_req = 1'b0;
      chki("merge_sends", n_send, 3);
      chki("merge_rcv", n_rcv, 1);
      chki("merge_valid", n_val, 1);
      chki("merge_overlap", overlap, 0);
      chkb("merge_idle_busy", busy, 1'b0);

      // Reset mid-burst with 3 bytes queued
      burst_to_tx();
      chkb("mid_send", send, 1'b1);
      chk8("mid_data", send_data, 8'hAB);
      rst_n = 1'b0;
      #1;
      chkb("mid_rst_send", send, 1'b0);
      chk8("mid_rst_data", send_data, 8'h00);
      step();
      rst_n = 1'b1;
      n_send = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         if (send) n_send++;
         step();
      end
      chki("post_rst_sends", n_send, 0);
      chkb("post_rst_ready", tx_ready, 1'b1);
      chkb("post_rst_busy", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
